// File: rtl/counter_bank.sv
// counter_bank: CH_NUM tick-driven down-counters with one-shot, auto-reload and PWM (`COUNTER_BANK_PWM_EN) modes.
// Latency: writes and tick edges update state on the next clk edge; rdata is combinational, zero cycles.
// Backpressure: none; every register write is accepted in the cycle it is presented.
module counter_bank #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32,
    parameter int AW     = $clog2(CH_NUM) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] tick,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [CH_NUM-1:0] ch_out,
    output logic              irq
);

    typedef struct packed {
        logic       ie;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    localparam logic [1:0] REG_LOAD = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_CMP  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    logic [CH_NUM-1:0] tick_q;
    logic [CNT_W-1:0]  load_q  [CH_NUM];
    logic [CNT_W-1:0]  load_d  [CH_NUM];
    logic [CNT_W-1:0]  count_q [CH_NUM];
    logic [CNT_W-1:0]  count_d [CH_NUM];
    ctrl_t             ctrl_q  [CH_NUM];
    ctrl_t             ctrl_d  [CH_NUM];
    logic [CH_NUM-1:0] flag_q, flag_d;
    logic [CH_NUM-1:0] done_q, done_d;      // one-shot has fired and is parked at 0
    logic [CH_NUM-1:0] ch_out_q, ch_out_d;
`ifdef COUNTER_BANK_PWM_EN
    logic [CNT_W-1:0]  cmp_q   [CH_NUM];
    logic [CNT_W-1:0]  cmp_d   [CH_NUM];
    logic [CH_NUM-1:0] wr_cmp;
    logic [CH_NUM-1:0] md_pwm;
`endif

    logic [31:0]       ch_sel;
    logic [CH_NUM-1:0] wr_load, wr_ctrl, wr_stat;
    logic [CH_NUM-1:0] tick_edge, en_eff, term;
    logic [CH_NUM-1:0] md_ar, md_os, ie_vec;
    logic [CNT_W-1:0]  wr_val;

    // Decode the addressed channel's write strobes, tick edges and effective mode per channel.
    always_comb begin
        ch_sel    = 32'(addr) >> 2;
        tick_edge = tick & ~tick_q;
        for (int i = 0; i < CH_NUM; i++) begin
            wr_load[i] = we && (ch_sel == 32'(i)) && (addr[1:0] == REG_LOAD);
            wr_ctrl[i] = we && (ch_sel == 32'(i)) && (addr[1:0] == REG_CTRL);
            wr_stat[i] = we && (ch_sel == 32'(i)) && (addr[1:0] == REG_STAT);
`ifdef COUNTER_BANK_PWM_EN
            wr_cmp[i]  = we && (ch_sel == 32'(i)) && (addr[1:0] == REG_CMP);
            md_pwm[i]  = (ctrl_q[i].mode == 2'b10);
            md_ar[i]   = (ctrl_q[i].mode == 2'b01);
`else
            md_ar[i]   = (ctrl_q[i].mode == 2'b01) || (ctrl_q[i].mode == 2'b10);
`endif
            md_os[i]   = (ctrl_q[i].mode == 2'b00) || (ctrl_q[i].mode == 2'b11);
            // a CTRL write clearing EN in the edge cycle must suppress that count
            en_eff[i]  = wr_ctrl[i] ? wdata[0] : ctrl_q[i].en;
            ie_vec[i]  = ctrl_q[i].ie;
        end
    end

    // Channel next state: register writes, tick-edge counting and terminal events.
    always_comb begin
        wr_val = wdata[CNT_W-1:0];
        for (int i = 0; i < CH_NUM; i++) begin
            load_d[i]  = load_q[i];
            count_d[i] = count_q[i];
            ctrl_d[i]  = ctrl_q[i];
            flag_d[i]  = flag_q[i];
            done_d[i]  = done_q[i];
            term[i]    = 1'b0;
`ifdef COUNTER_BANK_PWM_EN
            cmp_d[i]   = cmp_q[i];
            if (wr_cmp[i]) cmp_d[i] = wr_val;
`endif
            if (wr_ctrl[i]) ctrl_d[i] = ctrl_t'(wdata[3:0]);
            // a LOAD write beats a coincident tick edge; the tick is dropped
            if (wr_load[i]) begin
                load_d[i]  = wr_val;
                count_d[i] = wr_val;
                done_d[i]  = 1'b0;
            end else if (en_eff[i] && tick_edge[i] && !(md_os[i] && done_q[i])) begin
                if (count_q[i] != '0) begin
                    count_d[i] = count_q[i] - CNT_W'(1);
                end else begin
                    term[i] = 1'b1;
                    if (md_os[i]) done_d[i] = 1'b1;
                    else          count_d[i] = load_q[i];
                end
            end
            // terminal-event set takes priority over a software clear
            if (wr_stat[i] && wdata[0]) flag_d[i] = 1'b0;
            if (term[i])                flag_d[i] = 1'b1;
            ch_out_d[i] = md_ar[i] ? term[i] : done_d[i];
`ifdef COUNTER_BANK_PWM_EN
            if (md_pwm[i]) ch_out_d[i] = (count_q[i] < cmp_q[i]);
`endif
        end
    end

    // Combinational register read for the addressed channel; unmapped channels read 0.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_sel == 32'(i)) begin
                case (addr[1:0])
                    REG_LOAD: rdata = 32'(load_q[i]);
                    REG_CTRL: rdata = 32'(ctrl_q[i]);
`ifdef COUNTER_BANK_PWM_EN
                    REG_CMP:  rdata = 32'(cmp_q[i]);
`else
                    REG_CMP:  rdata = '0;
`endif
                    default: begin
                        rdata = 32'(count_q[i]);
                        // at full 32-bit width the count owns bit 31 and flag is irq-only
                        if (CNT_W < 32) rdata[31] = flag_q[i];
                    end
                endcase
            end
        end
    end

    assign ch_out = ch_out_q;
    assign irq    = |(flag_q & ie_vec);

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q   <= '0;
            flag_q   <= '0;
            done_q   <= '0;
            ch_out_q <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                load_q[i]  <= '0;
                count_q[i] <= '0;
                ctrl_q[i]  <= '0;
`ifdef COUNTER_BANK_PWM_EN
                cmp_q[i]   <= '0;
`endif
            end
        end else begin
            tick_q   <= tick;
            flag_q   <= flag_d;
            done_q   <= done_d;
            ch_out_q <= ch_out_d;
            for (int i = 0; i < CH_NUM; i++) begin
                load_q[i]  <= load_d[i];
                count_q[i] <= count_d[i];
                ctrl_q[i]  <= ctrl_d[i];
`ifdef COUNTER_BANK_PWM_EN
                cmp_q[i]   <= cmp_d[i];
`endif
            end
        end
    end

endmodule
